// File: rtl/riscv_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Misses write back a dirty victim, then refill the line over a word-wide req/ack bus.
module riscv_dcache #(
   parameter int NUM_LINES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dcache_read_req,
   input  logic        dcache_write_req,
   input  logic [11:0] dcache_addr,
   input  logic [31:0] dcache_write_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   output logic [31:0] dcache_read_data,
   output logic        dcache_hit,
   output logic        dcache_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 8 - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_e;

   state_e                 state_q, state_d;
   logic [1:0]             beat_q, beat_d;
   logic [TAG_W-1:0]       lat_tag_q, lat_tag_d;
   logic [IDX_W-1:0]       lat_idx_q, lat_idx_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;

   logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
   logic [31:0]            data_mem [NUM_LINES][4];

   logic [TAG_W-1:0]       addr_tag;
   logic [IDX_W-1:0]       addr_idx;
   logic [1:0]             addr_word;
   logic                   req, lookup_hit, hit;
   logic [31:0]            hit_word, merged_word;
   logic [7:0]             load_byte;
   logic [15:0]            load_half;

   logic                   data_we, tag_we;
   logic [IDX_W-1:0]       data_widx;
   logic [1:0]             data_wword;
   logic [31:0]            data_wval;

   assign addr_tag   = dcache_addr[11:4+IDX_W];
   assign addr_idx   = dcache_addr[3+IDX_W:4];
   assign addr_word  = dcache_addr[3:2];
   assign req        = dcache_read_req | dcache_write_req;
   assign lookup_hit = req & valid_q[addr_idx] & (tag_mem[addr_idx] == addr_tag);
   assign hit        = lookup_hit & (state_q == S_IDLE);
   assign hit_word   = data_mem[addr_idx][addr_word];

   assign dcache_hit   = hit;
   assign dcache_stall = (req & ~hit) | (state_q != S_IDLE);

   // A simultaneous read and write request is a store, so no load data is returned.
   always_comb begin
      dcache_read_data = 32'h0;
      load_byte        = hit_word[{dcache_addr[1:0], 3'b000} +: 8];
      load_half        = dcache_addr[1] ? hit_word[31:16] : hit_word[15:0];
      if (hit && !dcache_write_req) begin
         case (mem_size)
            2'b00:   dcache_read_data = {{24{~mem_unsigned & load_byte[7]}}, load_byte};
            2'b01:   dcache_read_data = {{16{~mem_unsigned & load_half[15]}}, load_half};
            default: dcache_read_data = hit_word;
         endcase
      end
   end

   always_comb begin
      merged_word = hit_word;
      case (mem_size)
         2'b00:   merged_word[{dcache_addr[1:0], 3'b000} +: 8] = dcache_write_data[7:0];
         2'b01:   merged_word[{dcache_addr[1], 4'b0000} +: 16] = dcache_write_data[15:0];
         default: merged_word = dcache_write_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      lat_tag_d   = lat_tag_q;
      lat_idx_d   = lat_idx_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 12'h0;
      mem_wdata   = 32'h0;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      data_widx   = addr_idx;
      data_wword  = addr_word;
      data_wval   = merged_word;
      case (state_q)
         S_IDLE: begin
            beat_d = 2'd0;
            if (req && !lookup_hit) begin
               lat_tag_d = addr_tag;
               lat_idx_d = addr_idx;
               state_d   = (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_WB : S_FILL;
            end else if (hit && dcache_write_req) begin
               data_we           = 1'b1;
               dirty_d[addr_idx] = 1'b1;
            end
         end
         S_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_mem[lat_idx_q], lat_idx_q, beat_q, 2'b00};
            mem_wdata = data_mem[lat_idx_q][beat_q];
            if (mem_ack) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) state_d = S_FILL;
            end
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = {lat_tag_q, lat_idx_q, beat_q, 2'b00};
            if (mem_ack) begin
               data_we    = 1'b1;
               data_widx  = lat_idx_q;
               data_wword = beat_q;
               data_wval  = mem_rdata;
               beat_d     = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  valid_d[lat_idx_q] = 1'b1;
                  dirty_d[lat_idx_q] = 1'b0;
                  tag_we             = 1'b1;
                  state_d            = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         beat_q    <= 2'd0;
         lat_tag_q <= '0;
         lat_idx_q <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         lat_tag_q <= lat_tag_d;
         lat_idx_q <= lat_idx_d;
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
      end
   end

   // Tag and data storage carry no reset; valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (data_we) data_mem[data_widx][data_wword] <= data_wval;
      if (tag_we)  tag_mem[lat_idx_q] <= lat_tag_q;
   end

endmodule
